// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between the producer blocks, the round-robin arbiter and the
// FIFO write port.
interface fifo_wr_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 4
);
    localparam int OWN_W = $clog2(N_REQ);

    logic [N_REQ-1:0]        Req;
    logic [N_REQ*DATA_W-1:0] Req_data;
    logic                    Wr_Full;
    logic [N_REQ-1:0]        Gnt;
    logic [N_REQ-1:0]        Ack;
    logic                    Wr_en;
    logic [DATA_W-1:0]       Data_in;
    logic [OWN_W-1:0]        Owner;
    logic                    Busy;

    // Arbiter side: consumes requests and the full flag, drives grants and the FIFO write port.
    modport master (
        input  Req, Req_data, Wr_Full,
        output Gnt, Ack, Wr_en, Data_in, Owner, Busy
    );

    // Requester / FIFO side.
    modport slave (
        output Req, Req_data, Wr_Full,
        input  Gnt, Ack, Wr_en, Data_in, Owner, Busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter: grants one requester at a time for a burst of at
// most MAX_BURST beats, stalls on Wr_Full without releasing, and rotates priority
// so the previous owner becomes lowest priority.
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 4,
    parameter int MAX_BURST = 4
) (
    input logic               Wr_clk,
    input logic               reset,
    fifo_wr_arbiter_if.master bus
);
    localparam int         OWN_W     = $clog2(N_REQ);
    localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t            state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [OWN_W-1:0]  owner_q, owner_d;
    logic [OWN_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [3:0]        beat_cnt_q, beat_cnt_d;

    logic              any_req;
    logic              hi_found;
    logic [OWN_W-1:0]  hi_pick;
    logic [OWN_W-1:0]  lo_pick;
    logic [OWN_W-1:0]  pick;
    logic              owner_req;
    logic [DATA_W-1:0] owner_data;
    logic              busy;
    logic              wr_en;
    logic              release_now;

    // Round-robin pick: lowest requester at or above rr_ptr, else lowest overall (wrap).
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        any_req  = |bus.Req;
        hi_found = 1'b0;
        hi_pick  = '0;
        lo_pick  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.Req[i]) begin
                lo_pick = OWN_W'(i);
                if (i >= int'(rr_ptr_q)) begin
                    hi_found = 1'b1;
                    hi_pick  = OWN_W'(i);
                end
            end
        end
        pick = hi_found ? hi_pick : lo_pick;
    end

    // Select the current owner's request bit and beat.
    always_comb begin
        owner_req  = 1'b0;
        owner_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner_q == OWN_W'(i)) begin
                owner_req  = bus.Req[i];
                owner_data = bus.Req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Write strobe and release condition; a full FIFO stalls but never releases.
    always_comb begin
        busy        = (state_q == BURST);
        wr_en       = busy && owner_req && !bus.Wr_Full;
        release_now = busy && ((wr_en && (beat_cnt_q == LAST_BEAT)) || !owner_req);
    end

    // Next-state logic for the IDLE/BURST controller and its bookkeeping registers.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d     = BURST;
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                    owner_d     = pick;
                    beat_cnt_d  = '0;
                end
            end
            BURST: begin
                if (wr_en) begin
                    beat_cnt_d = beat_cnt_q + 4'd1;
                end
                if (release_now) begin
                    state_d    = IDLE;
                    gnt_d      = '0;
                    beat_cnt_d = '0;
                    rr_ptr_d   = (owner_q == OWN_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset clears everything so requester 0 has first priority.
    // NOTE: non-blocking assignments here so every register samples pre-edge values, independent of statement order.
    always_ff @(posedge Wr_clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign bus.Gnt     = gnt_q;
    assign bus.Ack     = gnt_q & {N_REQ{wr_en}};
    assign bus.Wr_en   = wr_en;
    assign bus.Data_in = busy ? owner_data : '0;
    assign bus.Owner   = owner_q;
    assign bus.Busy    = busy;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: reset checks, a cycle table of directed
// vectors, hand-written multi-cycle corner cases and a randomized run against a
// transaction-level priority-queue model.
module tb_fifo_wr_arbiter;
    localparam int N_REQ     = 4;
    localparam int DATA_W    = 4;
    localparam int MAX_BURST = 4;
    localparam int OWN_W     = $clog2(N_REQ);
    localparam int OBS_W     = 2*N_REQ + 1 + DATA_W + 1 + OWN_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) arb_if ();

    fifo_wr_arbiter #(
        .N_REQ(N_REQ), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)
    ) dut (
        .Wr_clk(clk),
        .reset (rst),
        .bus   (arb_if)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [N_REQ-1:0] r, input logic [N_REQ*DATA_W-1:0] d, input logic f);
        arb_if.Req      = r;
        arb_if.Req_data = d;
        arb_if.Wr_Full  = f;
    endtask

    function automatic logic [OBS_W-1:0] pack_obs(input logic [N_REQ-1:0] gnt, input logic [N_REQ-1:0] ack,
                                                   input logic wr, input logic [DATA_W-1:0] din,
                                                   input logic busy, input logic [OWN_W-1:0] owner);
        return {gnt, ack, wr, din, busy, busy ? owner : {OWN_W{1'b0}}};
    endfunction

    function automatic logic [OBS_W-1:0] dut_obs();
        return pack_obs(arb_if.Gnt, arb_if.Ack, arb_if.Wr_en, arb_if.Data_in, arb_if.Busy, arb_if.Owner);
    endfunction

    // ---------------- directed cycle table ----------------
    typedef struct {
        logic [N_REQ-1:0]        req;
        logic [N_REQ*DATA_W-1:0] data;
        logic                    full;
        logic [N_REQ-1:0]        gnt;
        logic                    wr;
        logic [DATA_W-1:0]       din;
        logic                    busy;
        logic [OWN_W-1:0]        owner;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [N_REQ-1:0] req, input logic [N_REQ*DATA_W-1:0] data,
                                input logic full, input logic [N_REQ-1:0] gnt, input logic wr,
                                input logic [DATA_W-1:0] din, input logic busy, input logic [OWN_W-1:0] owner);
        vec_t v;
        v.req = req; v.data = data; v.full = full; v.gnt = gnt;
        v.wr = wr; v.din = din; v.busy = busy; v.owner = owner;
        return v;
    endfunction

    // ---------------- reference model ----------------
    // Priority order kept as a queue; after a release it is rotated so the old owner is last.
    int  prio[$];
    bit  m_busy;
    int  m_owner;
    int  m_beats;

    task automatic model_reset();
        prio = {0, 1, 2, 3};
        m_busy = 0; m_owner = 0; m_beats = 0;
    endtask

    task automatic model_step(input logic [N_REQ-1:0] r, input bit wrote);
        if (m_busy) begin
            if (wrote) m_beats++;
            if ((wrote && m_beats == MAX_BURST) || !r[m_owner]) begin
                m_busy = 0;
                while (prio[$] != m_owner) prio.push_back(prio.pop_front());
            end
        end else begin
            foreach (prio[k]) begin
                if (!m_busy && r[prio[k]]) begin
                    m_busy = 1; m_owner = prio[k]; m_beats = 0;
                end
            end
        end
    endtask

    // Watchdog so the run can never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [OBS_W-1:0]        exp_obs;
        logic [9:0]              pat;
        logic [4:0]              pat5;
        logic [31:0]             seq;
        logic [39:0]             owners, exp_owners;
        logic [DATA_W-1:0]       d;
        logic [N_REQ-1:0]        req_v, exp_gnt, last_ack;
        logic [N_REQ*DATA_W-1:0] data_v;
        logic                    full_v, wr_seen;
        bit                      m_wr;
        int                      nw, bad_ack, bad_data, own;

        // Row format: req, data(r3..r0), full | gnt, wr, Data_in, busy, owner
        vecs.push_back(mk(4'b0001, 16'h0005, 0, 4'b0000, 0, 4'h0, 0, 0));
        vecs.push_back(mk(4'b0001, 16'h0005, 0, 4'b0001, 1, 4'h5, 1, 0));
        vecs.push_back(mk(4'b0001, 16'h0006, 0, 4'b0001, 1, 4'h6, 1, 0));
        vecs.push_back(mk(4'b0001, 16'h0007, 0, 4'b0001, 1, 4'h7, 1, 0));
        vecs.push_back(mk(4'b0000, 16'h0000, 0, 4'b0001, 0, 4'h0, 1, 0));
        vecs.push_back(mk(4'b0011, 16'h0039, 0, 4'b0000, 0, 4'h0, 0, 0));
        vecs.push_back(mk(4'b0011, 16'h0039, 0, 4'b0010, 1, 4'h3, 1, 1));
        vecs.push_back(mk(4'b0001, 16'h0009, 0, 4'b0010, 0, 4'h0, 1, 1));
        vecs.push_back(mk(4'b0001, 16'h0009, 0, 4'b0000, 0, 4'h0, 0, 0));
        vecs.push_back(mk(4'b0001, 16'h0009, 0, 4'b0001, 1, 4'h9, 1, 0));
        vecs.push_back(mk(4'b0001, 16'h000A, 1, 4'b0001, 0, 4'hA, 1, 0));
        vecs.push_back(mk(4'b0001, 16'h000A, 0, 4'b0001, 1, 4'hA, 1, 0));
        vecs.push_back(mk(4'b0000, 16'h0000, 0, 4'b0001, 0, 4'h0, 1, 0));
        vecs.push_back(mk(4'b1000, 16'hA000, 0, 4'b0000, 0, 4'h0, 0, 0));
        vecs.push_back(mk(4'b1001, 16'hA001, 0, 4'b1000, 1, 4'hA, 1, 3));
        vecs.push_back(mk(4'b0001, 16'h0001, 0, 4'b1000, 0, 4'h0, 1, 3));
        vecs.push_back(mk(4'b1001, 16'hB001, 0, 4'b0000, 0, 4'h0, 0, 0));
        vecs.push_back(mk(4'b1001, 16'hB001, 0, 4'b0001, 1, 4'h1, 1, 0));
        vecs.push_back(mk(4'b1000, 16'hB000, 0, 4'b0001, 0, 4'h0, 1, 0));
        vecs.push_back(mk(4'b1000, 16'hB000, 0, 4'b0000, 0, 4'h0, 0, 0));
        vecs.push_back(mk(4'b1000, 16'hB000, 0, 4'b1000, 1, 4'hB, 1, 3));
        vecs.push_back(mk(4'b0000, 16'h0000, 0, 4'b1000, 0, 4'h0, 1, 3));
        vecs.push_back(mk(4'b0000, 16'h0000, 0, 4'b0000, 0, 4'h0, 0, 0));

        // ---- reset state ----
        rst = 1'b1;
        drive('0, '0, 1'b0);
        #3;
        check("reset_outputs", dut_obs(), '0);
        check("reset_owner", arb_if.Owner, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // ---- directed table ----
        for (int r = 0; r < vecs.size(); r++) begin
            drive(vecs[r].req, vecs[r].data, vecs[r].full);
            @(negedge clk);
            exp_obs = pack_obs(vecs[r].gnt, vecs[r].wr ? vecs[r].gnt : '0, vecs[r].wr,
                               vecs[r].din, vecs[r].busy, vecs[r].owner);
            check($sformatf("vec%0d", r), dut_obs(), exp_obs);
            @(posedge clk); #1;
        end

        // ---- burst limit: sole requester held continuously ----
        pat = '0; d = 4'd1; seq = '0; nw = 0;
        for (int c = 0; c < 10; c++) begin
            drive(4'b0001, {12'h000, d}, 1'b0);
            @(negedge clk);
            pat[c] = arb_if.Wr_en;
            if (arb_if.Wr_en) begin
                if (nw < 8) seq = seq | (32'(arb_if.Data_in) << (4*nw));
                nw++;
            end
            @(posedge clk); #1;
            if (pat[c]) d = d + 4'd1;
        end
        check("burst_limit_pattern", pat, 10'b1111011110);
        check("burst_limit_data", seq, 32'h87654321);
        drive('0, '0, 1'b0);
        @(negedge clk);
        check("burst_limit_release", arb_if.Busy, 0);
        @(posedge clk); #1;

        // ---- round robin with all four requesting ----
        owners = '0; nw = 0; bad_ack = 0; bad_data = 0;
        drive(4'b1111, {4'd3, 4'd2, 4'd1, 4'd0}, 1'b0);
        for (int c = 0; c < 60 && nw < 20; c++) begin
            @(negedge clk);
            if (arb_if.Wr_en) begin
                own = int'(arb_if.Owner);
                owners[2*nw +: 2] = 2'(own);
                if (arb_if.Ack != (4'b0001 << own) || arb_if.Gnt != arb_if.Ack) bad_ack++;
                if (arb_if.Data_in != DATA_W'(own)) bad_data++;
                nw++;
            end else if (arb_if.Ack != '0) begin
                bad_ack++;
            end
            @(posedge clk); #1;
        end
        for (int w = 0; w < 20; w++) exp_owners[2*w +: 2] = 2'((1 + w/4) % 4);
        check("rr_write_count", nw, 20);
        check("rr_owner_seq", owners, exp_owners);
        check("rr_ack_only_owner", bad_ack, 0);
        check("rr_data", bad_data, 0);
        drive('0, '0, 1'b0);

        // ---- full stall in the middle of a burst (requester 2) ----
        d = 4'd1; seq = '0; nw = 0;
        for (int c = 0; c < 9; c++) begin
            full_v = (c >= 3 && c <= 5);
            drive((c < 8) ? 4'b0100 : 4'b0000, {4'h0, d, 8'h00}, full_v);
            @(negedge clk);
            wr_seen = arb_if.Wr_en;
            if (full_v)
                check($sformatf("stall_c%0d", c), {arb_if.Wr_en, arb_if.Gnt, arb_if.Data_in, arb_if.Busy},
                      {1'b0, 4'b0100, 4'd3, 1'b1});
            if (c == 8) check("stall_release", arb_if.Busy, 0);
            if (wr_seen) begin
                if (nw < 8) seq = seq | (32'(arb_if.Data_in) << (4*nw));
                nw++;
            end
            @(posedge clk); #1;
            if (wr_seen) d = d + 4'd1;
        end
        check("stall_data", seq, 32'h4321);

        // ---- reset asserted mid-burst of requester 2 ----
        d = 4'd5;
        drive(4'b0100, {4'h0, d, 8'h00}, 1'b0);
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_first_beat", {arb_if.Wr_en, arb_if.Data_in}, {1'b1, 4'd5});
        @(posedge clk); #1;
        d = 4'd6;
        drive(4'b0100, {4'h0, d, 8'h00}, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("mid_reset_drop", {arb_if.Gnt, arb_if.Ack, arb_if.Wr_en, arb_if.Busy, arb_if.Data_in}, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_reset_idle", arb_if.Busy, 0);
        @(posedge clk); #1;
        pat5 = '0; seq = '0; nw = 0;
        for (int c = 0; c < 5; c++) begin
            drive((c < 4) ? 4'b0100 : 4'b0000, {4'h0, d, 8'h00}, 1'b0);
            @(negedge clk);
            if (c == 0) check("regrant_gnt", arb_if.Gnt, 4'b0100);
            pat5[c] = arb_if.Wr_en;
            if (arb_if.Wr_en) begin
                if (nw < 8) seq = seq | (32'(arb_if.Data_in) << (4*nw));
                nw++;
            end
            @(posedge clk); #1;
            if (pat5[c]) d = d + 4'd1;
        end
        check("regrant_full_burst", pat5, 5'b01111);
        check("regrant_data", seq, 32'h9876);

        // ---- randomized run against the model ----
        drive('0, '0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
        req_v = '0; data_v = '0; last_ack = '0;
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_v[i] && m_busy && m_owner == i && !last_ack[i]) begin
                    // granted beat still pending: must hold request and data
                end else if (req_v[i]) begin
                    if ($urandom_range(3) == 0) req_v[i] = 1'b0;
                    else if (last_ack[i]) data_v[i*DATA_W +: DATA_W] = DATA_W'($urandom);
                end else if ($urandom_range(2) == 0) begin
                    req_v[i] = 1'b1;
                    data_v[i*DATA_W +: DATA_W] = DATA_W'($urandom);
                end
            end
            full_v = ($urandom_range(3) == 0);
            drive(req_v, data_v, full_v);
            @(negedge clk);
            m_wr = m_busy && req_v[m_owner] && !full_v;
            exp_gnt = '0;
            if (m_busy) exp_gnt[m_owner] = 1'b1;
            exp_obs = pack_obs(exp_gnt, m_wr ? exp_gnt : '0, m_wr,
                               m_busy ? data_v[m_owner*DATA_W +: DATA_W] : '0,
                               m_busy, OWN_W'(m_owner));
            check($sformatf("rand_cyc%0d", cyc), dut_obs(), exp_obs);
            last_ack = m_wr ? exp_gnt : '0;
            @(posedge clk); #1;
            model_step(req_v, m_wr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
